// File: rtl/uart_rx_if.sv
// Receive-side bundle for uart_rx: serial line in, recovered byte and strobes out.
// Optional macro UART_RX_PARITY_EN adds the parity_err strobe.
interface uart_rx_if;
  logic       rx;
  logic [7:0] data;
  logic       valid;
  logic       frame_err;
  logic       busy;
`ifdef UART_RX_PARITY_EN
  logic       parity_err;
`endif

  // Receiver side: consumes rx, produces the byte and status strobes.
  modport master (
    input  rx,
    output data,
    output valid,
    output frame_err,
`ifdef UART_RX_PARITY_EN
    output parity_err,
`endif
    output busy
  );

  // Line driver / byte consumer side.
  modport slave (
    output rx,
    input  data,
    input  valid,
    input  frame_err,
`ifdef UART_RX_PARITY_EN
    input  parity_err,
`endif
    input  busy
  );
endinterface

// File: rtl/uart_rx.sv
// uart_rx: 8N1 asynchronous serial receiver with a 2-flop input synchronizer.
// Define UART_RX_PARITY_EN for 8E1 framing with a parity_err strobe.
module uart_rx #(
  parameter int unsigned CLK_HZ = 100000000,
  parameter int unsigned BAUD   = 115200
) (
  input logic      clk,
  input logic      rst,
  uart_rx_if.master bus
);

  localparam int unsigned CLKS_PER_BIT = CLK_HZ / BAUD;
  localparam int unsigned HALF_BIT     = CLKS_PER_BIT / 2;
  localparam int unsigned CntW         = $clog2(CLKS_PER_BIT);

  localparam logic [CntW-1:0] BitLast  = CntW'(CLKS_PER_BIT - 1);
  localparam logic [CntW-1:0] HalfLast = CntW'(HALF_BIT - 1);

  typedef enum logic [2:0] {
    StWaitHigh,
    StIdle,
    StStart,
    StData,
`ifdef UART_RX_PARITY_EN
    StParity,
`endif
    StStop
  } state_e;

  state_e          state_q, state_d;
  logic            sync_q, rx_s_q;
  logic [CntW-1:0] baud_q, baud_d;
  logic [2:0]      bit_q, bit_d;
  logic [7:0]      shift_q, shift_d;
  logic [7:0]      data_q, data_d;
  logic            valid_q, valid_d;
  logic            frame_err_q, frame_err_d;
`ifdef UART_RX_PARITY_EN
  logic            parity_err_q, parity_err_d;
  logic            par_bad_q, par_bad_d;
`endif

  // Two-flop synchronizer for the asynchronous line; resets to idle-high.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= 1'b1;
      rx_s_q <= 1'b1;
    end else begin
      sync_q <= bus.rx;
      rx_s_q <= sync_q;
    end
  end

  // Receiver state, counters, shift register and registered strobes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= StWaitHigh;
      baud_q       <= '0;
      bit_q        <= '0;
      shift_q      <= '0;
      data_q       <= '0;
      valid_q      <= 1'b0;
      frame_err_q  <= 1'b0;
`ifdef UART_RX_PARITY_EN
      parity_err_q <= 1'b0;
      par_bad_q    <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      baud_q       <= baud_d;
      bit_q        <= bit_d;
      shift_q      <= shift_d;
      data_q       <= data_d;
      valid_q      <= valid_d;
      frame_err_q  <= frame_err_d;
`ifdef UART_RX_PARITY_EN
      parity_err_q <= parity_err_d;
      par_bad_q    <= par_bad_d;
`endif
    end
  end

  // Next-state logic: all sampling happens at bit centres on the synchronized line.
  always_comb begin
    state_d      = state_q;
    baud_d       = baud_q;
    bit_d        = bit_q;
    shift_d      = shift_q;
    data_d       = data_q;
    valid_d      = 1'b0;
    frame_err_d  = 1'b0;
`ifdef UART_RX_PARITY_EN
    parity_err_d = 1'b0;
    par_bad_d    = par_bad_q;
`endif
    case (state_q)
      // A line held low (reset release, break) must go high before a start is accepted.
      StWaitHigh: begin
        if (rx_s_q) state_d = StIdle;
      end
      StIdle: begin
        if (!rx_s_q) begin
          state_d = StStart;
          baud_d  = '0;
        end
      end
      StStart: begin
        if (baud_q == HalfLast) begin
          baud_d = '0;
          bit_d  = '0;
          state_d = rx_s_q ? StIdle : StData;
        end else begin
          baud_d = baud_q + CntW'(1);
        end
      end
      StData: begin
        if (baud_q == BitLast) begin
          baud_d  = '0;
          shift_d = {rx_s_q, shift_q[7:1]};
          if (bit_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
            state_d = StParity;
`else
            state_d = StStop;
`endif
          end else begin
            bit_d = bit_q + 3'd1;
          end
        end else begin
          baud_d = baud_q + CntW'(1);
        end
      end
`ifdef UART_RX_PARITY_EN
      // Even parity: received bit must equal the XOR of the data bits.
      StParity: begin
        if (baud_q == BitLast) begin
          baud_d    = '0;
          par_bad_d = rx_s_q ^ (^shift_q);
          state_d   = StStop;
        end else begin
          baud_d = baud_q + CntW'(1);
        end
      end
`endif
      // Leave at mid-stop-bit so a following start edge is not missed.
      StStop: begin
        if (baud_q == BitLast) begin
          baud_d = '0;
          if (rx_s_q) begin
            state_d = StIdle;
`ifdef UART_RX_PARITY_EN
            if (par_bad_q) begin
              parity_err_d = 1'b1;
            end else begin
              data_d  = shift_q;
              valid_d = 1'b1;
            end
`else
            data_d  = shift_q;
            valid_d = 1'b1;
`endif
          end else begin
            frame_err_d = 1'b1;
            state_d     = StWaitHigh;
          end
        end else begin
          baud_d = baud_q + CntW'(1);
        end
      end
      default: state_d = StWaitHigh;
    endcase
  end

  assign bus.data       = data_q;
  assign bus.valid      = valid_q;
  assign bus.frame_err  = frame_err_q;
  assign bus.busy       = (state_q != StIdle) && (state_q != StWaitHigh);
`ifdef UART_RX_PARITY_EN
  assign bus.parity_err = parity_err_q;
`endif

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx at 16 clocks per bit.
module tb_uart_rx;
  localparam int unsigned Cpb = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;

  int         valid_cnt = 0;
  int         ferr_cnt = 0;
  int         perr_cnt = 0;
  int         both_cnt = 0;
  int         last_valid_cyc = 0;
  int         valid_gap = 0;
  logic [7:0] last_data = 8'h00;
  logic [7:0] first_data [$];

  uart_rx_if u_if ();

  uart_rx #(
    .CLK_HZ(1600000),
    .BAUD  (100000)
  ) u_dut (
    .clk(clk),
    .rst(rst),
    .bus(u_if.master)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Strobe monitor, sampled away from the active edge.
  always @(negedge clk) begin
    if (u_if.valid) begin
      valid_cnt = valid_cnt + 1;
      valid_gap = cyc - last_valid_cyc;
      last_valid_cyc = cyc;
      last_data = u_if.data;
      first_data.push_back(u_if.data);
    end
    if (u_if.frame_err) ferr_cnt = ferr_cnt + 1;
    if (u_if.valid && u_if.frame_err) both_cnt = both_cnt + 1;
`ifdef UART_RX_PARITY_EN
    if (u_if.parity_err) perr_cnt = perr_cnt + 1;
`endif
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks = checks + 1;
    if (got !== exp) begin
      errors = errors + 1;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic hold(input logic b, input int n);
    u_if.rx = b;
    repeat (n) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop_bit,
                            input logic use_par, input logic par_bit);
    hold(1'b0, Cpb);
    for (int i = 0; i < 8; i++) hold(b[i], Cpb);
    if (use_par) hold(par_bit, Cpb);
    hold(stop_bit, Cpb);
  endtask

  initial begin
    int v0;
    int f0;
    logic [7:0] b;
    u_if.rx = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_data", {24'h0, u_if.data}, 32'h00);
    check("rst_valid", {31'h0, u_if.valid}, 32'h0);
    check("rst_ferr", {31'h0, u_if.frame_err}, 32'h0);
    check("rst_busy", {31'h0, u_if.busy}, 32'h0);
    rst = 1'b0;
    repeat (10) @(negedge clk);

    // Single frame
    send_frame(8'h55, 1'b1, 1'b0, 1'b0);
    repeat (6) @(negedge clk);
    check("f55_cnt", valid_cnt, 1);
    check("f55_data", {24'h0, last_data}, 32'h55);
    check("f55_port", {24'h0, u_if.data}, 32'h55);
    check("f55_ferr", ferr_cnt, 0);
    check("f55_busy", {31'h0, u_if.busy}, 32'h0);

    // Back-to-back frames, no idle gap
    first_data.delete();
    send_frame(8'hA3, 1'b1, 1'b0, 1'b0);
    send_frame(8'h0F, 1'b1, 1'b0, 1'b0);
    repeat (6) @(negedge clk);
    check("b2b_cnt", valid_cnt, 3);
    check("b2b_first", (first_data.size() > 0) ? {24'h0, first_data[0]} : 32'hdead, 32'hA3);
    check("b2b_second", {24'h0, last_data}, 32'h0F);
    check("b2b_gap", {31'h0, (valid_gap >= 158 && valid_gap <= 162)}, 32'h1);

    // Short glitch is rejected
    hold(1'b0, 4);
    hold(1'b1, 40);
    check("glitch_cnt", valid_cnt, 3);
    check("glitch_ferr", ferr_cnt, 0);
    check("glitch_busy", {31'h0, u_if.busy}, 32'h0);
    send_frame(8'h81, 1'b1, 1'b0, 1'b0);
    repeat (6) @(negedge clk);
    check("f81_cnt", valid_cnt, 4);
    check("f81_data", {24'h0, u_if.data}, 32'h81);

    // Framing error, then line held low
    send_frame(8'hFF, 1'b0, 1'b0, 1'b0);
    hold(1'b0, 50);
    check("ferr_cnt", ferr_cnt, 1);
    check("ferr_valid", valid_cnt, 4);
    check("ferr_data", {24'h0, u_if.data}, 32'h81);
    hold(1'b1, 20);
    check("ferr_low_cnt", ferr_cnt, 1);
    send_frame(8'h3C, 1'b1, 1'b0, 1'b0);
    repeat (6) @(negedge clk);
    check("f3c_cnt", valid_cnt, 5);
    check("f3c_data", {24'h0, u_if.data}, 32'h3C);

    // Reset pulsed during bit 5 of 0xF0
    b = 8'hF0;
    hold(1'b0, Cpb);
    for (int i = 0; i < 5; i++) hold(b[i], Cpb);
    hold(b[5], 8);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check("mrst_data", {24'h0, u_if.data}, 32'h00);
    check("mrst_valid", {31'h0, u_if.valid}, 32'h0);
    check("mrst_busy", {31'h0, u_if.busy}, 32'h0);
    check("mrst_ferr", {31'h0, u_if.frame_err}, 32'h0);
    rst = 1'b0;
    hold(b[5], 5);
    hold(b[6], Cpb);
    hold(b[7], Cpb);
    hold(1'b1, Cpb);
    hold(1'b1, 10);
    check("mrst_cnt", valid_cnt, 5);
    check("mrst_ferr_cnt", ferr_cnt, 1);
    check("mrst_hold", {24'h0, u_if.data}, 32'h00);
    send_frame(8'h5A, 1'b1, 1'b0, 1'b0);
    repeat (6) @(negedge clk);
    check("f5a_cnt", valid_cnt, 6);
    check("f5a_data", {24'h0, u_if.data}, 32'h5A);

`ifdef UART_RX_PARITY_EN
    // 0x07 has three ones: even parity bit is 1
    v0 = valid_cnt;
    f0 = perr_cnt;
    send_frame(8'h07, 1'b1, 1'b1, 1'b1);
    repeat (6) @(negedge clk);
    check("par_ok_cnt", valid_cnt, v0 + 1);
    check("par_ok_data", {24'h0, u_if.data}, 32'h07);
    check("par_ok_perr", perr_cnt, f0);
    send_frame(8'h07, 1'b1, 1'b1, 1'b0);
    repeat (6) @(negedge clk);
    check("par_bad_perr", perr_cnt, f0 + 1);
    check("par_bad_cnt", valid_cnt, v0 + 1);
    check("par_bad_data", {24'h0, u_if.data}, 32'h07);
`else
    v0 = valid_cnt;
    f0 = ferr_cnt;
    send_frame(8'h00, 1'b1, 1'b0, 1'b0);
    repeat (6) @(negedge clk);
    check("f00_cnt", valid_cnt, v0 + 1);
    check("f00_data", {24'h0, u_if.data}, 32'h00);
    check("f00_ferr", ferr_cnt, f0);
`endif

    check("never_both", both_cnt, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
